// File: rtl/d_cache_mem_port_if.sv
// Request/response and main-memory channel bundle for d_cache_mem_port.
// The slave modport is the port block; the master modport is the LSU/memory side.
`ifndef D_CACHE_MEM_PORT_DEFS
`define D_CACHE_MEM_PORT_DEFS
`define ONE_BYTE          3'b000
`define TWO_BYTE          3'b001
`define FOUR_BYTE         3'b010
`define EIGHT_BYTE        3'b011
`define MEM_NOP           2'b00
`define MEM_READ          2'b01
`define MEM_WRITE         2'b10
`define MEM_RESTING       2'b00
`define MEM_DATA_FINISHED 2'b01
`define MEM_INST_FINISHED 2'b10
`endif

interface d_cache_mem_port_if #(
  parameter int ADDR_WIDTH       = 17,
  parameter int DATA_LEN         = 32,
  parameter int VECTOR_SIZE      = 8,
  parameter int ENTRY_INDEX_SIZE = 3
);
  logic                            req_valid;
  logic                            req_ready;
  logic                            req_write;
  logic [ADDR_WIDTH-1:0]           req_addr;
  logic [ENTRY_INDEX_SIZE:0]       req_length;
  logic [2:0]                      req_data_type;
  logic [VECTOR_SIZE*DATA_LEN-1:0] req_wdata;
  logic                            resp_valid;
  logic [VECTOR_SIZE*DATA_LEN-1:0] resp_rdata;
  logic [1:0]                      mem_vis_signal;
  logic [ADDR_WIDTH-1:0]           mem_vis_addr;
  logic [DATA_LEN-1:0]             mem_written_data;
  logic [2:0]                      mem_data_type;
  logic [ENTRY_INDEX_SIZE:0]       mem_length;
  logic [DATA_LEN-1:0]             mem_data;
  logic [1:0]                      mem_status;

  modport slave (
    input  req_valid, req_write, req_addr, req_length, req_data_type, req_wdata,
    input  mem_data, mem_status,
    output req_ready, resp_valid, resp_rdata,
    output mem_vis_signal, mem_vis_addr, mem_written_data, mem_data_type, mem_length
  );

  modport master (
    output req_valid, req_write, req_addr, req_length, req_data_type, req_wdata,
    output mem_data, mem_status,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_vis_signal, mem_vis_addr, mem_written_data, mem_data_type, mem_length
  );
endinterface

// File: rtl/d_cache_mem_port.sv
// Data-side memory port: serialises one scalar/vector load or store into 4-byte
// main-memory beats, retrying any beat the memory did not finish for the d-side.
`ifndef D_CACHE_MEM_PORT_DEFS
`define D_CACHE_MEM_PORT_DEFS
`define ONE_BYTE          3'b000
`define TWO_BYTE          3'b001
`define FOUR_BYTE         3'b010
`define EIGHT_BYTE        3'b011
`define MEM_NOP           2'b00
`define MEM_READ          2'b01
`define MEM_WRITE         2'b10
`define MEM_RESTING       2'b00
`define MEM_DATA_FINISHED 2'b01
`define MEM_INST_FINISHED 2'b10
`endif

module d_cache_mem_port #(
  parameter int ADDR_WIDTH       = 17,
  parameter int DATA_LEN         = 32,
  parameter int VECTOR_SIZE      = 8,
  parameter int ENTRY_INDEX_SIZE = 3
) (
  input logic               clk,
  input logic               rst,
  d_cache_mem_port_if.slave bus
);

  localparam int LEN_W = ENTRY_INDEX_SIZE + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                    state;
  logic                      write_q;
  logic [LEN_W-1:0]          len_q;
  logic [LEN_W-1:0]          beat_q;
  logic [LEN_W-1:0]          beat_nxt;
  logic [LEN_W-1:0]          eff_len;
  logic [ENTRY_INDEX_SIZE-1:0] cur_idx;
  logic [ENTRY_INDEX_SIZE-1:0] nxt_idx;
  logic [DATA_LEN-1:0]       wdata_q [VECTOR_SIZE];
  logic [DATA_LEN-1:0]       rdata_q [VECTOR_SIZE];

  // Clamp to the vector size; a scalar 8-byte access becomes two word beats.
  always_comb begin
    eff_len = bus.req_length;
    if (bus.req_length > LEN_W'(VECTOR_SIZE))
      eff_len = LEN_W'(VECTOR_SIZE);
    else if (bus.req_length == LEN_W'(1) && bus.req_data_type == `EIGHT_BYTE)
      eff_len = LEN_W'(2);
  end

  always_comb begin
    beat_nxt = beat_q + LEN_W'(1);
    cur_idx  = beat_q[ENTRY_INDEX_SIZE-1:0];
    nxt_idx  = beat_nxt[ENTRY_INDEX_SIZE-1:0];
  end

  always_comb begin
    bus.resp_rdata = '0;
    for (int unsigned i = 0; i < VECTOR_SIZE; i++)
      bus.resp_rdata[i*DATA_LEN +: DATA_LEN] = rdata_q[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      write_q              <= 1'b0;
      len_q                <= '0;
      beat_q               <= '0;
      bus.req_ready        <= 1'b1;
      bus.resp_valid       <= 1'b0;
      bus.mem_vis_signal   <= `MEM_NOP;
      bus.mem_vis_addr     <= '0;
      bus.mem_written_data <= '0;
      bus.mem_data_type    <= '0;
      bus.mem_length       <= '0;
      for (int unsigned i = 0; i < VECTOR_SIZE; i++) begin
        wdata_q[i] <= '0;
        rdata_q[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            write_q              <= bus.req_write;
            len_q                <= eff_len;
            beat_q               <= '0;
            bus.req_ready        <= 1'b0;
            bus.mem_length       <= eff_len;
            bus.mem_data_type    <= (eff_len == LEN_W'(1)) ? bus.req_data_type : `FOUR_BYTE;
            bus.mem_vis_addr     <= bus.req_addr;
            bus.mem_written_data <= bus.req_wdata[DATA_LEN-1:0];
            for (int unsigned i = 0; i < VECTOR_SIZE; i++) begin
              wdata_q[i] <= bus.req_wdata[i*DATA_LEN +: DATA_LEN];
              rdata_q[i] <= '0;
            end
            if (eff_len == '0) begin
              state          <= DONE;
              bus.resp_valid <= 1'b1;
            end else begin
              state              <= ISSUE;
              bus.mem_vis_signal <= bus.req_write ? `MEM_WRITE : `MEM_READ;
            end
          end
        end
        ISSUE: begin
          state              <= WAIT;
          bus.mem_vis_signal <= `MEM_NOP;
        end
        WAIT: begin
          // Anything but a d-side finish means this beat was not serviced: reissue it.
          if (bus.mem_status == `MEM_DATA_FINISHED) begin
            if (!write_q)
              rdata_q[cur_idx] <= bus.mem_data;
            beat_q <= beat_nxt;
            if (beat_nxt == len_q) begin
              state          <= DONE;
              bus.resp_valid <= 1'b1;
            end else begin
              state                <= ISSUE;
              bus.mem_vis_signal   <= write_q ? `MEM_WRITE : `MEM_READ;
              bus.mem_vis_addr     <= bus.mem_vis_addr + ADDR_WIDTH'(4);
              bus.mem_written_data <= wdata_q[nxt_idx];
            end
          end else begin
            state              <= ISSUE;
            bus.mem_vis_signal <= write_q ? `MEM_WRITE : `MEM_READ;
          end
        end
        DONE: begin
          state          <= IDLE;
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_d_cache_mem_port.sv
// Scoreboard bench for d_cache_mem_port: a byte-array memory model answers beats,
// a forked monitor checks every memory beat and every response against queued expectations.
`ifndef D_CACHE_MEM_PORT_DEFS
`define D_CACHE_MEM_PORT_DEFS
`define ONE_BYTE          3'b000
`define TWO_BYTE          3'b001
`define FOUR_BYTE         3'b010
`define EIGHT_BYTE        3'b011
`define MEM_NOP           2'b00
`define MEM_READ          2'b01
`define MEM_WRITE         2'b10
`define MEM_RESTING       2'b00
`define MEM_DATA_FINISHED 2'b01
`define MEM_INST_FINISHED 2'b10
`endif

module tb_d_cache_mem_port;

  typedef struct {
    logic [1:0]  sig;
    logic [16:0] addr;
    logic [31:0] data;
    logic [2:0]  dt;
    logic [3:0]  len;
  } beat_t;

  typedef struct {
    int unsigned  cyc;
    logic [255:0] rdata;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned rd_issue = 0;
  int unsigned force_at = 0;
  logic force_en = 1'b0;
  logic [7:0] mem [131072];
  beat_t bq [$];
  resp_t sb [$];

  d_cache_mem_port_if #(.ADDR_WIDTH(17), .DATA_LEN(32), .VECTOR_SIZE(8), .ENTRY_INDEX_SIZE(3)) bus ();

  d_cache_mem_port #(
    .ADDR_WIDTH(17), .DATA_LEN(32), .VECTOR_SIZE(8), .ENTRY_INDEX_SIZE(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pb(input logic [16:0] x);
    logic [31:0] t;
    t = 32'(x) * 7 + 3;
    return t[7:0];
  endfunction

  function automatic logic [31:0] pat_word(input logic [16:0] a);
    return {pb(a), pb(17'(a + 1)), pb(17'(a + 2)), pb(17'(a + 3))};
  endfunction

  // Memory model: status and data registered one edge after the beat is presented.
  initial begin
    logic [16:0] a;
    for (int i = 0; i < 131072; i++) mem[i] = pb(17'(i));
    mem[17'h1048] = 8'h11; mem[17'h1049] = 8'h22;
    mem[17'h104A] = 8'h33; mem[17'h104B] = 8'h44;
    bus.mem_status <= `MEM_RESTING;
    bus.mem_data   <= '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        bus.mem_status <= `MEM_RESTING;
        bus.mem_data   <= '0;
      end else begin
        a = bus.mem_vis_addr;
        if (bus.mem_vis_signal == `MEM_READ) begin
          if (force_en && rd_issue == force_at) begin
            bus.mem_status <= `MEM_INST_FINISHED;
            bus.mem_data   <= 32'hDEADBEEF;
          end else begin
            bus.mem_status <= `MEM_DATA_FINISHED;
            bus.mem_data   <= {mem[a], mem[17'(a + 1)], mem[17'(a + 2)], mem[17'(a + 3)]};
          end
          rd_issue = rd_issue + 1;
        end else if (bus.mem_vis_signal == `MEM_WRITE) begin
          mem[a]          = bus.mem_written_data[31:24];
          mem[17'(a + 1)] = bus.mem_written_data[23:16];
          mem[17'(a + 2)] = bus.mem_written_data[15:8];
          mem[17'(a + 3)] = bus.mem_written_data[7:0];
          bus.mem_status <= `MEM_DATA_FINISHED;
        end else begin
          bus.mem_status <= `MEM_RESTING;
        end
      end
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  256'(bus.req_ready), 256'(1));
    check({tag, "_resp_valid"}, 256'(bus.resp_valid), 256'(0));
    check({tag, "_resp_rdata"}, bus.resp_rdata, '0);
    check({tag, "_mem_sig"},    256'(bus.mem_vis_signal), 256'(`MEM_NOP));
    check({tag, "_mem_addr"},   256'(bus.mem_vis_addr), 256'(0));
    check({tag, "_mem_wdata"},  256'(bus.mem_written_data), 256'(0));
    check({tag, "_mem_len"},    256'({bus.mem_data_type, bus.mem_length}), 256'(0));
  endtask

  task automatic push_beats(input logic [1:0] sig, input logic [16:0] base, input int unsigned n,
                            input logic [255:0] wd, input logic [2:0] dt, input logic [3:0] len);
    beat_t b;
    for (int unsigned i = 0; i < n; i++) begin
      b.sig  = sig;
      b.addr = base + 17'(4 * i);
      b.data = wd[i*32 +: 32];
      b.dt   = dt;
      b.len  = len;
      bq.push_back(b);
    end
  endtask

  task automatic accept(input logic wr, input logic [16:0] a, input logic [3:0] len,
                        input logic [2:0] dt, input logic [255:0] wd, output int unsigned acc);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
    end
    bus.req_valid     = 1'b1;
    bus.req_write     = wr;
    bus.req_addr      = a;
    bus.req_length    = len;
    bus.req_data_type = dt;
    bus.req_wdata     = wd;
    acc = cyc;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic run_req(input logic wr, input logic [16:0] a, input logic [3:0] len,
                         input logic [2:0] dt, input logic [255:0] wd,
                         input logic [255:0] exp_rd, input int unsigned lat);
    int unsigned acc;
    int unsigned n;
    resp_t r;
    accept(wr, a, len, dt, wd, acc);
    r.cyc   = acc + lat;
    r.rdata = exp_rd;
    sb.push_back(r);
    n = 0;
    while ((sb.size() != 0 || bq.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || bq.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL completion_timeout: got %0d/%0d pending expected 0", sb.size(), bq.size());
      sb.delete();
      bq.delete();
    end
  endtask

  task automatic monitor();
    beat_t b;
    resp_t r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.mem_vis_signal != `MEM_NOP) begin
          if (bq.size() == 0) begin
            check("unexpected_beat", 256'({bus.mem_vis_signal, bus.mem_vis_addr}), 256'(0));
          end else begin
            b = bq.pop_front();
            check("beat_sig",  256'(bus.mem_vis_signal), 256'(b.sig));
            check("beat_addr", 256'(bus.mem_vis_addr), 256'(b.addr));
            check("beat_type", 256'({bus.mem_data_type, bus.mem_length}), 256'({b.dt, b.len}));
            if (b.sig == `MEM_WRITE)
              check("beat_wdata", 256'(bus.mem_written_data), 256'(b.data));
          end
        end
        if (bus.resp_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_resp", 256'(1), 256'(0));
          end else begin
            r = sb.pop_front();
            check("resp_cycle", 256'(cyc), 256'(r.cyc));
            check("resp_rdata", bus.resp_rdata, r.rdata);
          end
        end
      end
    end
  endtask

  initial begin
    logic [255:0] wd;
    logic [255:0] exp;
    int unsigned acc;

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_length = '0; bus.req_data_type = '0; bus.req_wdata = '0;

    fork
      monitor();
      begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
      end
    join_none

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Scalar FOUR_BYTE load.
    push_beats(`MEM_READ, 17'h1048, 1, '0, `FOUR_BYTE, 4'd1);
    run_req(1'b0, 17'h1048, 4'd1, `FOUR_BYTE, '0, 256'h11223344, 3);

    // Vector store then readback.
    for (int i = 0; i < 8; i++) wd[i*32 +: 32] = 32'hA0000000 + 32'(i);
    push_beats(`MEM_WRITE, 17'h100, 8, wd, `FOUR_BYTE, 4'd8);
    run_req(1'b1, 17'h100, 4'd8, `FOUR_BYTE, wd, '0, 17);
    push_beats(`MEM_READ, 17'h100, 8, '0, `FOUR_BYTE, 4'd8);
    run_req(1'b0, 17'h100, 4'd8, `FOUR_BYTE, '0, wd, 17);

    // Scalar ONE_BYTE load after a full vector: upper elements must be cleared.
    push_beats(`MEM_READ, 17'h1048, 1, '0, `ONE_BYTE, 4'd1);
    run_req(1'b0, 17'h1048, 4'd1, `ONE_BYTE, '0, 256'h11223344, 3);

    // Vector load wrapping past the top of the address space.
    for (int i = 0; i < 8; i++) exp[i*32 +: 32] = pat_word(17'h1FFFC + 17'(4 * i));
    push_beats(`MEM_READ, 17'h1FFFC, 8, '0, `FOUR_BYTE, 4'd8);
    run_req(1'b0, 17'h1FFFC, 4'd8, `FOUR_BYTE, '0, exp, 17);

    // Length 15 clamps to 8 beats.
    for (int i = 0; i < 8; i++) exp[i*32 +: 32] = pat_word(17'h300 + 17'(4 * i));
    push_beats(`MEM_READ, 17'h300, 8, '0, `FOUR_BYTE, 4'd8);
    run_req(1'b0, 17'h300, 4'd15, `FOUR_BYTE, '0, exp, 17);

    // Len-4 load with beat 2 answered for the i-side: beat 2 reissued, +2 cycles.
    exp = '0;
    for (int i = 0; i < 4; i++) exp[i*32 +: 32] = pat_word(17'h2000 + 17'(4 * i));
    push_beats(`MEM_READ, 17'h2000, 3, '0, `FOUR_BYTE, 4'd4);
    push_beats(`MEM_READ, 17'h2008, 2, '0, `FOUR_BYTE, 4'd4);
    force_at = rd_issue + 2;
    force_en = 1'b1;
    run_req(1'b0, 17'h2000, 4'd4, `FOUR_BYTE, '0, exp, 11);
    force_en = 1'b0;

    // Scalar EIGHT_BYTE store splits into two word beats; readback.
    wd = '0;
    wd[31:0]  = 32'hCAFEF00D;
    wd[63:32] = 32'h12345678;
    push_beats(`MEM_WRITE, 17'h200, 2, wd, `FOUR_BYTE, 4'd2);
    run_req(1'b1, 17'h200, 4'd1, `EIGHT_BYTE, wd, '0, 5);
    push_beats(`MEM_READ, 17'h200, 2, '0, `FOUR_BYTE, 4'd2);
    run_req(1'b0, 17'h200, 4'd2, `FOUR_BYTE, '0, wd, 5);

    // Length 0: no memory traffic.
    run_req(1'b0, 17'h400, 4'd0, `FOUR_BYTE, '0, '0, 1);

    // Reset during WAIT of beat 3 of a len-8 load.
    push_beats(`MEM_READ, 17'h3000, 4, '0, `FOUR_BYTE, 4'd8);
    accept(1'b0, 17'h3000, 4'd8, `FOUR_BYTE, '0, acc);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    check("midreset_beats_seen", 256'(bq.size()), 256'(0));
    bq.delete();
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    push_beats(`MEM_READ, 17'h1048, 1, '0, `FOUR_BYTE, 4'd1);
    run_req(1'b0, 17'h1048, 4'd1, `FOUR_BYTE, '0, 256'h11223344, 3);

    repeat (5) @(negedge clk);
    check("final_sb_empty", 256'(sb.size() + bq.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/d_cache_mem_port.md
# d_cache_mem_port

Data-side port that sits directly upstream of main memory on the `d_cache_mem_vis_*` channel. It accepts one scalar or vector (up to VECTOR_SIZE words) load/store request from the data cache/LSU and serialises it into 4-byte main-memory beats. Each beat is handshaken on `mem_status`. Read beats are gathered into a wide response buffer, which is returned with a single-cycle valid pulse.

## Interface
- ADDR_WIDTH, 17, byte-address width (matches main memory)
- DATA_LEN, 32, memory beat width
- VECTOR_SIZE, 8, max words per request
- ENTRY_INDEX_SIZE, 3, log2(VECTOR_SIZE); length field is ENTRY_INDEX_SIZE+1 bits

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (IDLE only)
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  byte address of element 0
- req_length  in  ENTRY_INDEX_SIZE+1  word count
- req_data_type  in  3  `ONE_BYTE/`TWO_BYTE/`FOUR_BYTE/`EIGHT_BYTE
- req_wdata  in  VECTOR_SIZE*DATA_LEN  element i in [i*32+:32]
- resp_valid  out  1  one-cycle completion pulse (loads and stores)
- resp_rdata  out  VECTOR_SIZE*DATA_LEN  gathered load data, element i in [i*32+:32]
- mem_vis_signal  out  2  `MEM_NOP/`MEM_READ/`MEM_WRITE to main memory
- mem_vis_addr  out  ADDR_WIDTH  beat address
- mem_written_data  out  DATA_LEN  beat store data
- mem_data_type  out  3  beat data type
- mem_length  out  ENTRY_INDEX_SIZE+1  latched effective length (informational)
- mem_data  in  DATA_LEN  memory read data
- mem_status  in  2  `MEM_RESTING/`MEM_DATA_FINISHED/`MEM_INST_FINISHED

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: `req_ready`=1. On `req_valid`, latch request fields, clear beat counter and `resp_rdata`, then go to ISSUE.
- Effective length:
  - 0 → no memory traffic; go straight to DONE.
  - Greater than VECTOR_SIZE → clamp to VECTOR_SIZE.
  - `EIGHT_BYTE` with length 1 → 2 beats of `FOUR_BYTE`.
- Beat data type: latched `req_data_type` when the effective length is 1, else `FOUR_BYTE`.
- ISSUE: drive `mem_vis_signal` = READ or WRITE.
  - `mem_vis_addr` = addr + 4*beat, modulo 2^ADDR_WIDTH (wraps).
  - `mem_written_data` = wdata element[beat], verbatim; the caller aligns bytes to [31:24].
  - Next state: WAIT.
- WAIT: drive `mem_vis_signal` = NOP.
  - If `mem_status` == `MEM_DATA_FINISHED`: on a load, capture `mem_data` into element[beat]; increment beat. Go to DONE if beat was the last, else ISSUE.
  - Any other status (`MEM_INST_FINISHED`, i.e. memory serviced the i-cache instead, or `MEM_RESTING`): retry the same beat by returning to ISSUE. No data is captured and retries are unbounded.
- DONE: `resp_valid`=1 for exactly one cycle, then IDLE. `resp_rdata` holds until the next request is accepted.
- Unused elements of `resp_rdata` read 0. For stores, `resp_rdata` is all zeros.
- Byte order inside each word is memory order: the byte at the lowest address lands in [31:24].

## Timing
- Reset values (asynchronous): state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `mem_vis_signal`=`MEM_NOP`, `mem_vis_addr`=0, `mem_written_data`=0, `mem_data_type`=0, `mem_length`=0.
- Reset mid-request aborts immediately and the request is lost. A store beat already sampled by memory stays committed.
- Beat cost: 2 cycles with no retries; memory registers its status and data one edge after ISSUE.
- Latency: acceptance edge at cycle 0, `resp_valid` in cycle 2N+1 for N beats; each retry adds 2 cycles. Length 0 gives `resp_valid` in cycle 1.
- `req_valid` while not in IDLE is ignored (`req_ready`=0). There is no back-to-back acceptance; the next request is accepted no earlier than the cycle after DONE.
- `mem_vis_*` outputs are registered; the address is stable through ISSUE.

## Test plan
- Scalar load, addr 0x1048, len 1, `FOUR_BYTE`, memory bytes 11 22 33 44 → one READ beat, `resp_rdata`[31:0]=0x11223344, `resp_valid` at cycle 3, other elements 0.
- Vector store, addr 0x100, len 8, wdata element i = 0xA0000000+i → 8 WRITE beats at 0x100..0x11C, `FOUR_BYTE`, `resp_valid` at cycle 17; memory readback matches.
- Vector load, len 8 at addr 0x1FFFC → second beat address wraps to 0x00000 and `resp_valid` at cycle 17.
- Force `mem_status`=`MEM_INST_FINISHED` on beat 2 of a len-4 load → beat 2 reissued at the same address, data not captured, `resp_valid` at cycle 11.
- Scalar `EIGHT_BYTE` store at 0x200 → two `FOUR_BYTE` WRITE beats at 0x200 and 0x204; len 0 request → no memory traffic, `resp_valid` at cycle 1.
- Assert `rst` during the WAIT state of beat 3 of a len-8 load → outputs return to reset values asynchronously, `resp_valid` never pulses, and a new request after reset completes normally.
